// File: rtl/complex_div_ctrl.sv
// Operand FIFO and start/finish sequencer for complex_division; latency pop+ARM+RUN(N), divide-by-zero resolves in 2 cycles.
// Backpressure: in_ready drops when the FIFO is full; HOLD keeps the result until out_ready.
module complex_div_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        div_start,
  output logic [63:0] div_a,
  output logic [63:0] div_b,
  input  logic        div_finish,
  input  logic [63:0] div_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_dz,
  output logic        out_timeout,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [63:0] NAN2 = 64'h7FC00000_7FC00000;

  typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [127:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   cnt;
  logic            rst_done;
  logic            push, pop, full, b_zero, cnt_last;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign in_ready = rst_done && !full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || (count != '0);
  // Signed zero counts as zero in both halves of the denominator.
  assign b_zero   = (div_b[62:32] == 31'd0) && (div_b[30:0] == 31'd0);
  assign cnt_last = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = ARM;
      end
      ARM:  state_nxt = b_zero ? HOLD : RUN;
      RUN:  if (div_finish || cnt_last) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      rst_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_start   <= 1'b0;
      div_a       <= '0;
      div_b       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_dz      <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_start <= (state_nxt == RUN);
      out_valid <= (state_nxt == HOLD);
      cnt       <= (state == RUN) ? cnt + CW'(1) : '0;
      if (pop) begin
        div_a <= mem[rd_ptr][127:64];
        div_b <= mem[rd_ptr][63:0];
      end
      if (state == ARM && b_zero) begin
        out_result  <= NAN2;
        out_dz      <= 1'b1;
        out_timeout <= 1'b0;
      end
      // A finish in the same cycle as the timeout wins.
      if (state == RUN) begin
        if (div_finish) begin
          out_result  <= div_result;
          out_dz      <= 1'b0;
          out_timeout <= 1'b0;
        end else if (cnt_last) begin
          out_result  <= NAN2;
          out_dz      <= 1'b0;
          out_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_div_ctrl.sv
// Scoreboarded bench for complex_div_ctrl with a behavioural 9-cycle divider model.
module tb_complex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, div_start, div_finish, out_valid, out_ready;
  logic        out_dz, out_timeout, busy, hang;
  logic [63:0] in_a, in_b, div_a, div_b, div_result, out_result;

  typedef struct packed {
    logic [63:0] res;
    logic        dz;
    logic        to;
  } exp_t;

  localparam logic [63:0] NAN2 = 64'h7FC00000_7FC00000;
  localparam logic [63:0] ONE2 = 64'h3F800000_3F800000;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0, got = 0, rise_cyc = 0, start_hi = 0, push_cyc = 0;
  int mcnt = 0;
  logic [63:0] fa [5];
  logic [63:0] fr [5];

  complex_div_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_finish(div_finish), .div_result(div_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_dz(out_dz),
    .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: finish is first sampled on the 9th RUN cycle, unless hung.
  assign div_result = {div_a[63:32], div_a[31:0] ^ div_b[31:0]};
  initial div_finish = 1'b0;
  always @(posedge clk) begin
    if (!div_start) begin
      mcnt       <= 0;
      div_finish <= 1'b0;
    end else begin
      mcnt       <= mcnt + 1;
      div_finish <= !hang && (mcnt + 1 == 8);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input exp_t e);
    int n = 0;
    sb.push_back(e);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("push_stall", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int target);
    int n = 0;
    while (got < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_count", 64'(got), 64'(target));
  endtask

  initial begin
    int s0, g0;
    logic [63:0] held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; hang = 1'b0;

    fork
      begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) prev = 1'b0;
          else begin
            if (div_start) start_hi++;
            if (out_valid && !prev) rise_cyc = cyc;
            prev = out_valid;
            if (out_valid && out_ready) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", out_result);
              end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("dz", {63'd0, out_dz}, {63'd0, e.dz});
                chk("timeout_flag", {63'd0, out_timeout}, {63'd0, e.to});
              end
              got++;
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_div_start", {63'd0, div_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_div_b", div_b, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("release_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("post_edge_in_ready", {63'd0, in_ready}, 64'd1);

    // Single operation: 1+1i / 1+1i through the model
    s0 = start_hi;
    push(ONE2, ONE2, '{res: 64'h3F800000_00000000, dz: 1'b0, to: 1'b0});
    wait_got(1);
    chk("single_latency", 64'(rise_cyc - push_cyc), 64'd11);
    chk("single_start_cycles", 64'(start_hi - s0), 64'd9);

    // Divide by zero with negative-zero real part
    s0 = start_hi;
    push(64'h40400000_40400000, 64'h80000000_00000000, '{res: NAN2, dz: 1'b1, to: 1'b0});
    wait_got(2);
    chk("dz_latency", 64'(rise_cyc - push_cyc), 64'd2);
    chk("dz_no_start", 64'(start_hi - s0), 64'd0);

    // Hung divider
    hang = 1'b1;
    s0 = start_hi;
    push(ONE2, 64'h40000000_00000000, '{res: NAN2, dz: 1'b0, to: 1'b1});
    wait_got(3);
    chk("timeout_latency", 64'(rise_cyc - push_cyc), 64'd66);
    chk("timeout_start_cycles", 64'(start_hi - s0), 64'd64);
    hang = 1'b0;

    // FIFO fill with consumer stalled, then hold and drain in order
    fa[0] = 64'h41000000_00000000; fr[0] = 64'h41000000_3F800000;
    fa[1] = 64'h41000001_00000001; fr[1] = 64'h41000001_3F800001;
    fa[2] = 64'h41000002_00000002; fr[2] = 64'h41000002_3F800002;
    fa[3] = 64'h41000003_00000003; fr[3] = 64'h41000003_3F800003;
    fa[4] = 64'h41000004_00000004; fr[4] = 64'h41000004_3F800004;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(fa[i], ONE2, '{res: fr[i], dz: 1'b0, to: 1'b0});
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_busy", {63'd0, busy}, 64'd1);
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("hold_reached", {63'd0, out_valid}, 64'd1);
    held = out_result;
    s0 = start_hi;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_stable", out_result, fr[0]);
    chk("hold_unchanged", out_result, held);
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_no_start", 64'(start_hi - s0), 64'd0);
    out_ready = 1'b1;
    wait_got(8);

    // Reset in the middle of RUN with a second op still queued
    push(ONE2, ONE2, '{res: 64'h3F800000_00000000, dz: 1'b0, to: 1'b0});
    push(fa[1], ONE2, '{res: fr[1], dz: 1'b0, to: 1'b0});
    for (int n = 0; n < 20 && !div_start; n++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_div_start", {63'd0, div_start}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    g0 = got;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_fifo_empty", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_idle", {63'd0, busy}, 64'd0);
    chk("midrst_no_results", 64'(got - g0), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
